test_block: RTL and testbench

//   Three-input glitch-filtered voter driving a single qualified output.
//   a_i/b_i/c_i are asynchronous level inputs, e.g. redundant status lines.

---
 rtl/test_block.sv | 82 ++++++++
 tb/tb_test_block.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/test_block.sv
// Glitch-filtered three-input voter: per-input synchronizer and persistence filter, registered vote on d_o.
// Build option: define TEST_UNANIMOUS_EN for the unanimous-with-hysteresis vote instead of 2-of-3 majority.
module test_block #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic d_o
);

  localparam int CNT_W = $clog2(FILT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_CYCLES - 1);

  logic [2:0] raw;
  logic [2:0] filt;
  logic       vote_d;

  assign raw = {c_i, b_i, a_i};

  for (genvar i = 0; i < 3; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] chain_q;
    logic                   synced;
    logic [CNT_W-1:0]       cnt_q;
    logic                   filt_q;

    if (SYNC_STAGES == 1) begin : g_one
      always_ff @(posedge clk) begin
        if (rst) chain_q <= '0;
        else     chain_q <= raw[i];
      end
    end else begin : g_multi
      always_ff @(posedge clk) begin
        if (rst) chain_q <= '0;
        else     chain_q <= {chain_q[SYNC_STAGES-2:0], raw[i]};
      end
    end

    assign synced = chain_q[SYNC_STAGES-1];

    // A differing level must persist FILT_CYCLES samples in a row; any return to the held level discards progress.
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q  <= '0;
        filt_q <= 1'b0;
      end else if (synced == filt_q) begin
        cnt_q  <= '0;
      end else if (cnt_q == CNT_LAST) begin
        filt_q <= synced;
        cnt_q  <= '0;
      end else begin
        cnt_q  <= cnt_q + 1'b1;
      end
    end

    assign filt[i] = filt_q;
  end

`ifdef TEST_UNANIMOUS_EN
  // Output only moves when all three filtered levels agree, otherwise it keeps its last value.
  always_comb begin
    vote_d = d_o;
    if (&filt)
      vote_d = 1'b1;
    else if (~|filt)
      vote_d = 1'b0;
  end
`else
  always_comb begin
    vote_d = (filt[0] & filt[1]) | (filt[0] & filt[2]) | (filt[1] & filt[2]);
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) d_o <= 1'b0;
    else     d_o <= vote_d;
  end

endmodule

// File: tb/tb_test_block.sv
// Bench for test_block: two instances (default and 1/1 parameters) against a sample-history reference model.
// Honours TEST_UNANIMOUS_EN the same way as the design.
module tb_test_block;

  localparam int S0 = 2;
  localparam int F0 = 4;
  localparam int S1 = 1;
  localparam int F1 = 1;
  localparam int LAT0 = S0 + F0;
  localparam int LAT1 = S1 + F1;
`ifdef TEST_UNANIMOUS_EN
  localparam bit UNAN = 1'b1;
`else
  localparam bit UNAN = 1'b0;
`endif

  logic clk;
  logic rst;
  logic a, b, c;
  logic d_slow, d_fast;

  int n_checks = 0;
  int n_fails  = 0;

  test_block #(.SYNC_STAGES(S0), .FILT_CYCLES(F0)) dut (
    .clk(clk), .rst(rst), .a_i(a), .b_i(b), .c_i(c), .d_o(d_slow)
  );

  test_block #(.SYNC_STAGES(S1), .FILT_CYCLES(F1)) dut_fast (
    .clk(clk), .rst(rst), .a_i(a), .b_i(b), .c_i(c), .d_o(d_fast)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: a raw sample is seen by the filter S edges after it was taken; the filtered
  // level flips after F consecutive differing synced samples; the vote uses the levels before this edge.
  logic [2:0] hist [2][16];
  int         m_n   [2];
  logic [2:0] m_f   [2];
  int         m_run [2][3];
  logic       m_d   [2];
  int         m_s, m_fc, m_sum;
  logic [2:0] m_syn;

  task automatic model_step();
    for (int m = 0; m < 2; m++) begin
      if (rst) begin
        m_f[m] = 3'b000;
        m_d[m] = 1'b0;
        m_n[m] = 0;
        for (int j = 0; j < 3; j++) m_run[m][j] = 0;
      end else begin
        m_s  = (m == 0) ? S0 : S1;
        m_fc = (m == 0) ? F0 : F1;
        hist[m][m_n[m] % 16] = {c, b, a};
        m_syn = (m_n[m] >= m_s) ? hist[m][(m_n[m] - m_s) % 16] : 3'b000;
        m_n[m] = m_n[m] + 1;
        m_sum = int'(m_f[m][0]) + int'(m_f[m][1]) + int'(m_f[m][2]);
        if (UNAN) begin
          if (m_sum == 3)      m_d[m] = 1'b1;
          else if (m_sum == 0) m_d[m] = 1'b0;
        end else begin
          m_d[m] = (m_sum >= 2);
        end
        for (int j = 0; j < 3; j++) begin
          if (m_syn[j] == m_f[m][j]) begin
            m_run[m][j] = 0;
          end else begin
            m_run[m][j] = m_run[m][j] + 1;
            if (m_run[m][j] >= m_fc) begin
              m_f[m][j]   = m_syn[j];
              m_run[m][j] = 0;
            end
          end
        end
      end
    end
  endtask

  always @(posedge clk) model_step();

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; a = 1'b1; b = 1'b1; c = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_checks++;
      if (d_slow !== 1'b0 || d_fast !== 1'b0) begin
        n_fails++;
        $display("[TB] FAIL reset_hold: d_o=%b/%b, expected 0/0", d_slow, d_fast);
      end
    end
    rst = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      n_checks++;
      if (d_slow !== (k >= LAT0 + 1) || d_fast !== (k >= LAT1 + 1)) begin
        n_fails++;
        $display("[TB] FAIL reset_release edge %0d: d_o=%b/%b, expected %b/%b",
                 k, d_slow, d_fast, k >= LAT0 + 1, k >= LAT1 + 1);
      end
      n_checks++;
      if (d_slow !== m_d[0] || d_fast !== m_d[1]) begin
        n_fails++;
        $display("[TB] FAIL reset_model: d_o=%b/%b, expected %b/%b", d_slow, d_fast, m_d[0], m_d[1]);
      end
    end
  endtask

  task automatic test_single_input();
    a = 1'b0; b = 1'b0; c = 1'b0;
    for (int k = 0; k < 12; k++) @(negedge clk);
    a = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      n_checks++;
      if (d_slow !== 1'b0 || d_fast !== 1'b0) begin
        n_fails++;
        $display("[TB] FAIL single_a: d_o=%b/%b, expected 0/0", d_slow, d_fast);
      end
    end
    b = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      n_checks++;
      if (d_slow !== (!UNAN && k >= LAT0 + 1) || d_fast !== (!UNAN && k >= LAT1 + 1)) begin
        n_fails++;
        $display("[TB] FAIL second_b edge %0d: d_o=%b/%b, expected %b/%b",
                 k, d_slow, d_fast, !UNAN && k >= LAT0 + 1, !UNAN && k >= LAT1 + 1);
      end
    end
  endtask

  task automatic test_pulse();
    b = 1'b0;
    for (int k = 0; k < 15; k++) @(negedge clk);
    b = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      n_checks++;
      if (d_slow !== 1'b0 || d_fast !== m_d[1]) begin
        n_fails++;
        $display("[TB] FAIL pulse3: d_o=%b/%b, expected 0/%b", d_slow, d_fast, m_d[1]);
      end
      if (k == 3) b = 1'b0;
    end
    b = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      n_checks++;
      if (d_slow !== (!UNAN && k >= 7 && k <= 10) || d_fast !== m_d[1]) begin
        n_fails++;
        $display("[TB] FAIL pulse4 edge %0d: d_o=%b/%b, expected %b/%b",
                 k, d_slow, d_fast, !UNAN && k >= 7 && k <= 10, m_d[1]);
      end
      if (k == 4) b = 1'b0;
    end
  endtask

  task automatic test_mid_reset();
    a = 1'b1; b = 1'b1; c = 1'b1;
    for (int k = 0; k < 12; k++) @(negedge clk);
    n_checks++;
    if (d_slow !== 1'b1 || d_fast !== 1'b1) begin
      n_fails++;
      $display("[TB] FAIL all_high: d_o=%b/%b, expected 1/1", d_slow, d_fast);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (d_slow !== 1'b0 || d_fast !== 1'b0) begin
      n_fails++;
      $display("[TB] FAIL mid_reset_edge: d_o=%b/%b, expected 0/0", d_slow, d_fast);
    end
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      n_checks++;
      if (d_slow !== (k >= LAT0 + 1) || d_fast !== (k >= LAT1 + 1)) begin
        n_fails++;
        $display("[TB] FAIL mid_reset_release edge %0d: d_o=%b/%b, expected %b/%b",
                 k, d_slow, d_fast, k >= LAT0 + 1, k >= LAT1 + 1);
      end
    end
  endtask

  task automatic test_drop_one();
    c = 1'b0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      n_checks++;
      if (d_slow !== 1'b1 || d_fast !== 1'b1) begin
        n_fails++;
        $display("[TB] FAIL drop_c: d_o=%b/%b, expected 1/1", d_slow, d_fast);
      end
    end
    a = 1'b0; b = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      n_checks++;
      if (d_slow !== (k < LAT0 + 1) || d_fast !== (k < LAT1 + 1)) begin
        n_fails++;
        $display("[TB] FAIL drop_all edge %0d: d_o=%b/%b, expected %b/%b",
                 k, d_slow, d_fast, k < LAT0 + 1, k < LAT1 + 1);
      end
    end
  endtask

  task automatic test_fast_path();
    a = 1'b0; b = 1'b0; c = 1'b0;
    for (int k = 0; k < 8; k++) @(negedge clk);
    a = 1'b1; b = 1'b1; c = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      n_checks++;
      if (d_fast !== (k >= 3) || d_slow !== 1'b0) begin
        n_fails++;
        $display("[TB] FAIL fast_rise edge %0d: d_o=%b/%b, expected 0/%b", k, d_slow, d_fast, k >= 3);
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      n_checks++;
      if (d_slow !== m_d[0] || d_fast !== m_d[1]) begin
        n_fails++;
        $display("[TB] FAIL random cycle %0d: d_o=%b/%b, expected %b/%b",
                 k, d_slow, d_fast, m_d[0], m_d[1]);
      end
      if ($urandom_range(3) == 0) a = ~a;
      if ($urandom_range(3) == 0) b = ~b;
      if ($urandom_range(3) == 0) c = ~c;
      rst = ($urandom_range(63) == 0);
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; a = 1'b0; b = 1'b0; c = 1'b0;
    $display("[TB] starting");
    test_reset();
    test_single_input();
    test_pulse();
    test_mid_reset();
    test_drop_one();
    test_fast_path();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
